lettore_tabella_verita: RTL and testbench
=========================================

// Module: lettore_tabella_verita
// PURPOSE
//  Sequential reader for a 3-in/2-out combinational network: drives inputs x through all 2^N_IN codes in
//  ascending order, waits SETTLE clocks per code for propagation, samples z and packs the observed
//  truth table. Compares each entry against the expected table EXPECTED and reports mismatches.
//  Sits in the test/bring-up layer next to the combinational networks it characterises.
// PARAMETERS
//  N_IN      3        width of x (network inputs); table depth = 2**N_IN
//  N_OUT     2        width of z (network outputs)
//  SETTLE    3        clocks between driving x and sampling z; legal range 1..15
//  EXPECTED  16'h0FA4 expected table, entry i at bits [N_OUT*i+N_OUT-1 : N_OUT*i]
//                     (default: 000->00 001->01 010->10 011->10 100->11 101->11 110->00 111->00)
// PORTS
//  clock          in   1                  system clock, all state on rising edge
//  reset          in   1                  synchronous, active-high
//  start          in   1                  request a full table read; sampled only in IDLE
//  x              out  N_IN               stimulus driven to network inputs (x[2]=x2 ... x[0]=x0)
//  z              in   N_OUT              network outputs (z[1]=z1, z[0]=z0)
//  busy           out  1                  high from accept of start until DONE state inclusive
//  done           out  1                  one-cycle pulse, table_out/mismatch valid from this cycle
//  table_out      out  N_OUT*2**N_IN      observed table, same packing as EXPECTED
//  mismatch       out  1                  sticky for the run: any entry differed from EXPECTED
//  err_count      out  N_IN+1             number of differing entries (0..2**N_IN)
//  first_err_idx  out  N_IN               index of lowest differing entry; 0 when err_count==0
// BEHAVIOUR
//  Reset (sync, overrides everything incl. mid-run): state=IDLE; x=0, busy=0, done=0, table_out=0,
//   mismatch=0, err_count=0, first_err_idx=0, idx=0, wait counter=0.
//  FSM states IDLE, WAIT, SAMPLE, DONE:
//   IDLE:   start=1 -> next edge: idx=0, x=0, cnt=SETTLE-1, clear table_out/mismatch/err_count/
//           first_err_idx, busy=1, go WAIT. start=0 -> stay; x held at 0.
//   WAIT:   cnt!=0 -> cnt-1; cnt==0 -> SAMPLE. State lasts exactly SETTLE cycles.
//   SAMPLE: table_out[entry idx] <= z; if z != EXPECTED entry: err_count+1, mismatch=1, and
//           first_err_idx=idx if this is the first error of the run. If idx==2**N_IN-1 -> DONE,
//           else idx+1, x=idx+1, cnt=SETTLE-1, -> WAIT.
//   DONE:   done=1 (this cycle only), busy=1; next edge -> IDLE, busy=0, x=0. start ignored here.
//  Timing: start accepted at edge E0; each code occupies SETTLE+1 cycles (SETTLE WAIT + 1 SAMPLE);
//   done is high in cycle 2**N_IN*(SETTLE+1)+1 after E0 (33 for defaults). x changes only on entry
//   to WAIT, so z is sampled >= SETTLE full cycles after x is stable.
//  start while busy is ignored (no restart, no queuing); start held high continuously -> a new run
//   begins in the first IDLE cycle, i.e. one cycle after done.
//  Results (table_out, mismatch, err_count, first_err_idx) hold after done until next accepted start
//   or reset. Partial results during a run are visible but not valid until done.
//  err_count width N_IN+1 so all-entries-wrong (8) never wraps. z is registered only in SAMPLE; no
//   X filtering -- X on z in SAMPLE is a bench error.
// TESTING
//  1 Golden network (default mapping, 20-unit delay < SETTLE clocks), pulse start -> done at
//    cycle 33, table_out=16'h0FA4, mismatch=0, err_count=0, first_err_idx=0, busy low after.
//  2 Faulty network returning 11 for x=110 -> table_out=16'h3FA4, mismatch=1, err_count=1,
//    first_err_idx=6.
//  3 Network outputs constant 11 -> err_count=6 (entries 0,1,2,3,6,7), first_err_idx=0,
//    table_out=16'hFFFF.
//  4 Reset asserted at cycle 10 of a run -> next cycle all outputs at reset values, x=0;
//    fresh start afterwards gives case-1 results exactly.
//  5 start held high for 80 cycles -> exactly two runs, done pulses at cycles 33 and 67, no
//    restart mid-run; extra start pulses during busy have no effect.
//  6 SETTLE=1 build, golden network -> done at cycle 17, x steps every 2 cycles 0..7, table 16'h0FA4.

Source files
------------

// File: rtl/lettore_tabella_verita_if.sv
// ----------------------------------------------------------------------------
// lettore_tabella_verita_if
// Bundle between the truth-table reader and the combinational network it
// characterises, plus the run-control / result signals seen by the host.
//
//   start          host -> reader   request one full table read
//   x              reader -> net    stimulus code driven to network inputs
//   z              net -> reader    network outputs
//   busy           reader -> host   run in progress (accept .. DONE inclusive)
//   done           reader -> host   one-cycle pulse, results valid from here
//   table_out      reader -> host   observed table, N_OUT bits per entry
//   mismatch       reader -> host   any entry differed from the expected table
//   err_count      reader -> host   number of differing entries
//   first_err_idx  reader -> host   lowest differing entry (0 if none)
//
// Modports: slave = the reader itself, master = host/bench side.
// ----------------------------------------------------------------------------
interface lettore_tabella_verita_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 2
);
    logic                          start;
    logic [N_IN-1:0]               x;
    logic [N_OUT-1:0]              z;
    logic                          busy;
    logic                          done;
    logic [N_OUT*(2**N_IN)-1:0]    table_out;
    logic                          mismatch;
    logic [N_IN:0]                 err_count;
    logic [N_IN-1:0]               first_err_idx;

    modport slave (
        input  start,
        input  z,
        output x,
        output busy,
        output done,
        output table_out,
        output mismatch,
        output err_count,
        output first_err_idx
    );

    modport master (
        output start,
        output z,
        input  x,
        input  busy,
        input  done,
        input  table_out,
        input  mismatch,
        input  err_count,
        input  first_err_idx
    );
endinterface

// File: rtl/lettore_tabella_verita.sv
// ----------------------------------------------------------------------------
// lettore_tabella_verita
// Sequential truth-table reader. Walks the network inputs x through every code
// in ascending order, lets each code settle for SETTLE clocks, samples z into
// the observed table and compares each entry with EXPECTED.
//
// Ports:
//   i_clock   system clock, all state on the rising edge
//   i_reset   synchronous, active-high; overrides everything, including a run
//   bus       lettore_tabella_verita_if.slave (start/x/z/busy/done/results)
//
// Parameters:
//   N_IN      network input width, table depth 2**N_IN
//   N_OUT     network output width
//   SETTLE    clocks between driving x and sampling z (1..15, 4-bit counter)
//   EXPECTED  expected table, entry i at [N_OUT*i +: N_OUT]
// ----------------------------------------------------------------------------
module lettore_tabella_verita #(
    parameter int unsigned N_IN     = 3,
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned SETTLE   = 3,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 16'h0FA4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    lettore_tabella_verita_if.slave   bus
);

    localparam int unsigned DEPTH = 2**N_IN;
    localparam int unsigned TW    = N_OUT*DEPTH;

    // WAIT lasts exactly SETTLE cycles: load SETTLE-1, leave when it hits 0.
    localparam logic [3:0]      CNT_INIT = 4'(SETTLE-1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [N_IN-1:0]    r_idx;
    logic [N_IN-1:0]    r_x;
    logic [3:0]         r_cnt;
    logic [TW-1:0]      r_table;
    logic               r_mismatch;
    logic [N_IN:0]      r_err_count;
    logic [N_IN-1:0]    r_first_err_idx;

    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_count;
    logic               w_sample;
    logic               w_last;
    logic               w_advance;
    logic               w_finish;
    logic [N_OUT-1:0]   w_z_exp;
    logic               w_z_err;

    assign w_last  = (r_idx == IDX_LAST);
    assign w_z_exp = EXPECTED[N_OUT*r_idx +: N_OUT];
    assign w_z_err = (bus.z != w_z_exp);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start)     w_next_state = S_WAIT;
            S_WAIT:   if (r_cnt == 4'd0) w_next_state = S_SAMPLE;
            S_SAMPLE: w_next_state = w_last ? S_DONE : S_WAIT;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_accept  = 1'b0;
        w_count   = 1'b0;
        w_sample  = 1'b0;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
            end
            S_WAIT: begin
                w_busy  = 1'b1;
                w_count = (r_cnt != 4'd0);
            end
            S_SAMPLE: begin
                w_busy    = 1'b1;
                w_sample  = 1'b1;
                w_advance = !w_last;
            end
            S_DONE: begin
                w_busy   = 1'b1;
                w_done   = 1'b1;
                w_finish = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: stimulus index, settle counter, observed table, results
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_idx           <= '0;
            r_x             <= '0;
            r_cnt           <= '0;
            r_table         <= '0;
            r_mismatch      <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
        end else begin
            if (w_accept) begin
                r_idx           <= '0;
                r_x             <= '0;
                r_cnt           <= CNT_INIT;
                r_table         <= '0;
                r_mismatch      <= 1'b0;
                r_err_count     <= '0;
                r_first_err_idx <= '0;
            end

            if (w_count) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_sample) begin
                r_table[N_OUT*r_idx +: N_OUT] <= bus.z;
                if (w_z_err) begin
                    r_mismatch  <= 1'b1;
                    r_err_count <= r_err_count + (N_IN+1)'(1);
                    // err_count still 0 means this is the first bad entry
                    if (r_err_count == '0) begin
                        r_first_err_idx <= r_idx;
                    end
                end
            end

            // x only moves on entry to WAIT, so every code gets a full settle
            if (w_advance) begin
                r_idx <= r_idx + N_IN'(1);
                r_x   <= r_idx + N_IN'(1);
                r_cnt <= CNT_INIT;
            end

            if (w_finish) begin
                r_x <= '0;
            end
        end
    end

    assign bus.x             = r_x;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.table_out     = r_table;
    assign bus.mismatch      = r_mismatch;
    assign bus.err_count     = r_err_count;
    assign bus.first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_lettore_tabella_verita.sv
module tb_lettore_tabella_verita;

    localparam logic [15:0] GOLD = 16'h0FA4;

    logic clk;
    logic rst;

    int n_chk = 0;
    int n_err = 0;

    lettore_tabella_verita_if #(.N_IN(3), .N_OUT(2)) ifa ();
    lettore_tabella_verita_if #(.N_IN(3), .N_OUT(2)) ifb ();

    lettore_tabella_verita #(.N_IN(3), .N_OUT(2), .SETTLE(3), .EXPECTED(GOLD)) dut_a (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (ifa)
    );

    lettore_tabella_verita #(.N_IN(3), .N_OUT(2), .SETTLE(1), .EXPECTED(GOLD)) dut_b (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Network models: a lookup table with propagation delay; output goes
    // unknown while settling so an early sample corrupts the table.
    logic [15:0] tab_a;
    logic [15:0] tab_b;

    always @(ifa.x or tab_a) begin
        ifa.z = 'x;
        #20;
        ifa.z = tab_a[{ifa.x, 1'b0} +: 2];
    end

    always @(ifb.x or tab_b) begin
        ifb.z = 'x;
        #2;
        ifb.z = tab_b[{ifb.x, 1'b0} +: 2];
    end

    typedef struct {
        logic [15:0] tab;
        logic [15:0] exp_tab;
        logic        exp_mis;
        logic [3:0]  exp_err;
        logic [2:0]  exp_first;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_net(input logic [15:0] t);
        tab_a = t;
        repeat (4) @(posedge clk);
    endtask

    // Reference model: compare the network's table against EXPECTED entry by entry.
    task automatic model(input logic [15:0] t, output logic [3:0] err, output logic [2:0] first);
        logic [15:0] e;
        e = GOLD;
        err = 0;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            if (t[2*i +: 2] != e[2*i +: 2]) begin
                if (err == 0) first = 3'(i);
                err++;
            end
        end
    endtask

    // Pulse start on DUT A, return the cycle (1 = first cycle after accept) where done is seen.
    task automatic run_a(input bit noise, output int dcyc);
        int busy_low;
        busy_low = 0;
        dcyc = -1;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            ifa.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!ifa.busy) busy_low++;
            if (ifa.done) begin
                ifa.start = 1'b0;
                dcyc = k;
                break;
            end
            @(posedge clk);
        end
        chk("busy_during_run", 32'(busy_low), 32'd0);
    endtask

    task automatic check_after(input string nm, input logic [15:0] et, input logic em,
                               input logic [3:0] ee, input logic [2:0] ef);
        chk({nm, "_table"}, 32'(ifa.table_out), 32'(et));
        chk({nm, "_mismatch"}, 32'(ifa.mismatch), 32'(em));
        chk({nm, "_err_count"}, 32'(ifa.err_count), 32'(ee));
        chk({nm, "_first_err"}, 32'(ifa.first_err_idx), 32'(ef));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(ifa.done), 32'd0);
        chk({nm, "_busy_after"}, 32'(ifa.busy), 32'd0);
        chk({nm, "_x_idle"}, 32'(ifa.x), 32'd0);
        chk({nm, "_table_hold"}, 32'(ifa.table_out), 32'(et));
    endtask

    initial begin
        int dc;
        int dq[$];
        logic [15:0] t;
        logic [3:0]  me;
        logic [2:0]  mf;

        vecs[0] = '{16'h0FA4, 16'h0FA4, 1'b0, 4'd0, 3'd0};
        vecs[1] = '{16'h3FA4, 16'h3FA4, 1'b1, 4'd1, 3'd6};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd6, 3'd0};
        vecs[3] = '{16'hF05B, 16'hF05B, 1'b1, 4'd8, 3'd0};
        vecs[4] = '{16'h4FA4, 16'h4FA4, 1'b1, 4'd1, 3'd7};

        rst = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        tab_a = GOLD;
        tab_b = GOLD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", 32'(ifa.x), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_table", 32'(ifa.table_out), 32'd0);
        chk("rst_mismatch", 32'(ifa.mismatch), 32'd0);
        chk("rst_err_count", 32'(ifa.err_count), 32'd0);
        chk("rst_first_err", 32'(ifa.first_err_idx), 32'd0);
        chk("rst_b_busy", 32'(ifb.busy), 32'd0);
        rst = 1'b0;

        // Table-driven runs
        for (int v = 0; v < 5; v++) begin
            set_net(vecs[v].tab);
            run_a(1'b0, dc);
            chk($sformatf("vec%0d_done_cycle", v), 32'(dc), 32'd33);
            check_after($sformatf("vec%0d", v), vecs[v].exp_tab, vecs[v].exp_mis,
                        vecs[v].exp_err, vecs[v].exp_first);
        end

        // Reset mid-run at cycle 10
        set_net(16'hFFFF);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        chk("midrun_err_partial", 32'(ifa.err_count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_x", 32'(ifa.x), 32'd0);
        chk("midrst_busy", 32'(ifa.busy), 32'd0);
        chk("midrst_done", 32'(ifa.done), 32'd0);
        chk("midrst_table", 32'(ifa.table_out), 32'd0);
        chk("midrst_mismatch", 32'(ifa.mismatch), 32'd0);
        chk("midrst_err_count", 32'(ifa.err_count), 32'd0);
        chk("midrst_first_err", 32'(ifa.first_err_idx), 32'd0);
        set_net(GOLD);
        run_a(1'b0, dc);
        chk("postrst_done_cycle", 32'(dc), 32'd33);
        check_after("postrst", GOLD, 1'b0, 4'd0, 3'd0);

        // start held high for 80 cycles
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (ifa.done) dq.push_back(k);
            if (k == 34 || k == 68) chk($sformatf("hold_idle_busy_c%0d", k), 32'(ifa.busy), 32'd0);
            @(posedge clk);
        end
        ifa.start = 1'b0;
        chk("hold_done_count", 32'(dq.size()), 32'd2);
        if (dq.size() >= 2) begin
            chk("hold_done1_cycle", 32'(dq[0]), 32'd33);
            chk("hold_done2_cycle", 32'(dq[1]), 32'd67);
        end
        dc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifa.done) begin
                dc = k;
                break;
            end
        end
        chk("hold_third_run_ends", 32'(dc >= 0), 32'd1);
        @(negedge clk);

        // Randomized networks against the reference model, start noise while busy
        for (int r = 0; r < 8; r++) begin
            t = 16'($urandom);
            model(t, me, mf);
            set_net(t);
            run_a(1'b1, dc);
            chk($sformatf("rnd%0d_done_cycle", r), 32'(dc), 32'd33);
            check_after($sformatf("rnd%0d", r), t, 1'(me != 0), me, mf);
        end

        // SETTLE=1 build
        @(negedge clk);
        ifb.start = 1'b1;
        @(posedge clk);
        dc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            if (k <= 16) chk($sformatf("b_x_c%0d", k), 32'(ifb.x), 32'((k - 1) / 2));
            if (ifb.done) begin
                dc = k;
                break;
            end
            @(posedge clk);
        end
        chk("b_done_cycle", 32'(dc), 32'd17);
        chk("b_table", 32'(ifb.table_out), 32'(GOLD));
        chk("b_mismatch", 32'(ifb.mismatch), 32'd0);
        @(negedge clk);
        chk("b_busy_after", 32'(ifb.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
